memory_arbiter: RTL
===================

# memory_arbiter

Two-port arbiter that shares the single CPU memory bus between the instruction-fetch port and the load/store data port. It sits between the core and memory, downstream of the load/store unit's address, write-strobe and write-data outputs. It grants one requester at a time using round-robin priority and holds the grant until the memory completes the transfer. The rdata path is forwarded to the granted requester.

## Interface
Parameters:
- `RESET_PRIORITY`, default 1: port favoured in the first arbitration after reset (0 = fetch, 1 = data).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  fetch request.
- `i_ready`  out  1  fetch transfer complete.
- `i_address`  in  word_t  fetch address.
- `i_rdata`  out  word_t  fetch read data.
- `d_valid`  in  1  data request.
- `d_ready`  out  1  data transfer complete.
- `d_address`  in  word_t  data address.
- `d_wstrobe`  in  wstrobe_t  byte write enables; all zero means a load.
- `d_wdata`  in  word_t  store data.
- `d_rdata`  out  word_t  load data.
- `m_valid`  out  1  memory request.
- `m_ready`  in  1  memory transfer complete.
- `m_address`  out  word_t  memory address.
- `m_wstrobe`  out  wstrobe_t  memory byte enables.
- `m_wdata`  out  word_t  memory write data.
- `m_rdata`  in  word_t  memory read data.

## Operation
- Handshake on every port: the requester raises `valid` and keeps it and its payload stable until it sees `ready`=1. The transfer completes in the cycle where `valid` and `ready` are both 1.
- FSM states: `IDLE`, `GRANT_I`, `GRANT_D`, held in a register.
- One priority bit `prio` (0 = fetch, 1 = data) sets the winner when both ports request.
- In `IDLE`:
  - if only one port is valid, go to that port's grant state;
  - if both are valid, go to the port named by `prio`;
  - if neither is valid, stay in `IDLE`.
- In `GRANT_x`:
  - `m_valid` = x_valid.
  - `m_address`, `m_wstrobe`, `m_wdata` are muxed from port x. Fetch always drives `m_wstrobe`=0 and `m_wdata`=0.
  - `x_ready` = `m_ready`. The other port's `ready` = 0.
  - `x_rdata` = `m_rdata`.
- Completion in `GRANT_x` (`m_valid`&`m_ready`):
  - `prio` is set to point at the other port.
  - If the other port's valid is 1 in that cycle, go directly to its grant state (back-to-back). Otherwise go to `IDLE`.
- If x_valid drops while granted (protocol violation), `m_valid` follows it to 0 and the grant is held. No error is flagged.
- Non-granted `rdata` outputs are 0 and `ready` outputs are 0.
- Outside grant states (`IDLE`): `m_valid`=0 and the `m_*` payload outputs are 0.

## Timing
- Reset, asynchronous: state=`IDLE`, `prio`=`RESET_PRIORITY`.
- Outputs while `reset`=1: `m_valid`=0, `i_ready`=0, `d_ready`=0, all payload and rdata outputs 0.
- Reset during a grant aborts the transfer immediately. `m_valid` falls without waiting for a clock edge.
- Arbitration latency: a request first seen in `IDLE` at cycle N drives `m_valid`=1 at cycle N+1.
- Memory returning `m_ready` in the same cycle as `m_valid` gives one cycle per transfer in the grant state.
- `ready` and `rdata` on the granted port are combinational from `m_ready` and `m_rdata`; there is no added latency.
- Back-to-back alternating requests: the grant switches in the cycle after completion, with no `IDLE` gap.
- A single port requesting continuously gets one transfer every 2 cycles (grant, then `IDLE`).
- Simultaneous new requests in `IDLE`: exactly one grant, chosen by `prio`.

## Structure
- `arbiter_state_t` enum (`IDLE`, `GRANT_I`, `GRANT_D`) goes in `types_pkg`, next to `word_t` and `wstrobe_t`.
- Single module; no sub-module. The next-state logic and the output mux are two `always_comb` blocks, and the state and `prio` registers are one `always_ff` block.

## Test plan
- Reset with both ports valid: hold `reset`=1 for 3 cycles → `m_valid`=0 and both `ready`=0 throughout. After release, the first grant goes to data (`RESET_PRIORITY`=1).
- Fetch only: `i_address`=0x100, memory ready after 2 wait cycles → `m_address`=0x100, `m_wstrobe`=0. `i_ready` pulses for 1 cycle with `i_rdata`=`m_rdata`=0xDEADBEEF, and `d_ready` stays 0.
- Store byte: `d_address`=0x2001, `d_wstrobe`=4'b0010, `d_wdata`=0x55555555 → identical values appear on `m_*`. `d_ready` rises in the `m_ready` cycle.
- Contention: both ports valid continuously with zero-wait memory → grants alternate D, I, D, I with no `IDLE` cycle between them, and each port completes every 2 cycles.
- Reset mid-transfer: assert `reset` during `GRANT_D` with `m_ready`=0 → `m_valid` is 0 in the same cycle. After release the state is `IDLE` and `prio` is restored.
- Late arrival: fetch is granted and waiting, then `d_valid` rises → `d_ready` stays 0 until the fetch completes. The data grant starts in the next cycle.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the CPU memory bus arbiter.
//   word_t          : 32-bit address / data word
//   wstrobe_t       : per-byte write enables (all zero = load)
//   arbiter_state_t : arbiter FSM state encoding
package types_pkg;

  localparam int WORD_W    = 32;
  localparam int STROBE_W  = WORD_W / 8;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [STROBE_W-1:0] wstrobe_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arbiter_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory bus between the instruction-fetch
// port (i_*) and the load/store data port (d_*). One requester is granted at a
// time and the grant is held until the memory completes the transfer.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   i_valid/i_ready/i_address      fetch request, completion, address
//   i_rdata                        fetch read data (0 unless granted)
//   d_valid/d_ready/d_address      data request, completion, address
//   d_wstrobe/d_wdata              byte enables (0 = load), store data
//   d_rdata                        load data (0 unless granted)
//   m_valid/m_ready/m_address      memory request, completion, address
//   m_wstrobe/m_wdata/m_rdata      memory byte enables, write/read data
//
// State   | meaning
// IDLE    | no grant; memory bus driven to zero
// GRANT_I | fetch port owns the bus
// GRANT_D | data port owns the bus
module memory_arbiter
  import types_pkg::*;
#(
  parameter logic RESET_PRIORITY = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_valid,
  output logic     i_ready,
  input  word_t    i_address,
  output word_t    i_rdata,
  input  logic     d_valid,
  output logic     d_ready,
  input  word_t    d_address,
  input  wstrobe_t d_wstrobe,
  input  word_t    d_wdata,
  output word_t    d_rdata,
  output logic     m_valid,
  input  logic     m_ready,
  output word_t    m_address,
  output wstrobe_t m_wstrobe,
  output word_t    m_wdata,
  input  word_t    m_rdata
);

  arbiter_state_t r_state;
  arbiter_state_t w_state_next;
  logic           r_prio;       // 0 = fetch favoured, 1 = data favoured
  logic           w_prio_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_prio  <= RESET_PRIORITY;
    end else begin
      r_state <= w_state_next;
      r_prio  <= w_prio_next;
    end
  end

  // Next-state and priority update.
  always_comb begin
    w_state_next = r_state;
    w_prio_next  = r_prio;
    unique case (r_state)
      IDLE: begin
        if (i_valid && d_valid) begin
          w_state_next = r_prio ? GRANT_D : GRANT_I;
        end else if (i_valid) begin
          w_state_next = GRANT_I;
        end else if (d_valid) begin
          w_state_next = GRANT_D;
        end
      end
      GRANT_I: begin
        // Completion hands priority to the other port and switches
        // straight to it when it is already waiting.
        if (i_valid && m_ready) begin
          w_prio_next  = 1'b1;
          w_state_next = d_valid ? GRANT_D : IDLE;
        end
      end
      GRANT_D: begin
        if (d_valid && m_ready) begin
          w_prio_next  = 1'b0;
          w_state_next = i_valid ? GRANT_I : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bus mux. Gating on reset keeps every output at zero for the whole
  // reset pulse, independent of when the state register responds.
  always_comb begin
    m_valid   = 1'b0;
    m_address = '0;
    m_wstrobe = '0;
    m_wdata   = '0;
    i_ready   = 1'b0;
    i_rdata   = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    if (!reset) begin
      unique case (r_state)
        GRANT_I: begin
          m_valid   = i_valid;
          m_address = i_address;
          i_ready   = m_ready;
          i_rdata   = m_rdata;
        end
        GRANT_D: begin
          m_valid   = d_valid;
          m_address = d_address;
          m_wstrobe = d_wstrobe;
          m_wdata   = d_wdata;
          d_ready   = m_ready;
          d_rdata   = m_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
